alu_32_bits: RTL and testbench

32-bit ARM-style data-processing ALU with a 4-bit opcode and registered NZCV flags.
- Computes one of 16 operations on A/B.
- Result and flags are captured into output registers on the clock edge when `en` is high.
- The stored C flag feeds the carry-using ops (ADC/SBC/RSC).
- Sits in the execute stage, between the register-file read and writeback.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_addsub.sv | 23 ++
 rtl/alu_32_bits.sv | 75 +++++++
 tb/tb_alu_32_bits.sv | 110 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag indices and default width shared by the ALU files
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_RSB = 4'b0011,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSC = 4'b0111,
    OP_TST = 4'b1000,
    OP_TEQ = 4'b1001,
    OP_CMP = 4'b1010,
    OP_CMN = 4'b1011,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_BIC = 4'b1110,
    OP_MVN = 4'b1111
  } alu_op_e;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: (WIDTH+1)-bit adder with per-operand inversion, carry-in, carry-out and signed overflow
module alu_addsub #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert_a,
  input  logic             invert_b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  logic [WIDTH-1:0] x, y;
  logic [WIDTH:0]   s;
  assign x = invert_a ? ~a : a;
  assign y = invert_b ? ~b : b;
  assign s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign sum = s[WIDTH-1:0];
  assign cout = s[WIDTH];
  // Overflow is judged on the operands as actually presented to the adder
  assign ovf = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
endmodule

// File: rtl/alu_32_bits.sv
// alu_32_bits: ARM-style data-processing ALU with registered Result and NZCV flags.
// Optional macro ALU_PARITY_EN adds a registered Parity output (XOR of Result).
module alu_32_bits
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Op,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
`ifdef ALU_PARITY_EN
  ,
  output logic             Parity
`endif
);
  alu_op_e          op;
  logic [WIDTH-1:0] logic_res, sum, result_d, result_q;
  logic [3:0]       flags_d, flags_q;
  logic             inv_a, inv_b, cin, cout, ovf, arith;
  assign op = alu_op_e'(ALU_Op);
  assign arith = op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
  assign inv_a = op inside {OP_RSB, OP_RSC};
  assign inv_b = op inside {OP_SUB, OP_SBC, OP_CMP};
  assign cin = (op inside {OP_SUB, OP_RSB, OP_CMP}) ? 1'b1 :
               (op inside {OP_ADC, OP_SBC, OP_RSC}) ? flags_q[FLAG_C] : 1'b0;
  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(A),
    .b(B),
    .invert_a(inv_a),
    .invert_b(inv_b),
    .cin(cin),
    .sum(sum),
    .cout(cout),
    .ovf(ovf)
  );
  always_comb begin
    logic_res = A & B;
    case (op)
      OP_EOR, OP_TEQ: logic_res = A ^ B;
      OP_ORR:         logic_res = A | B;
      OP_MOV:         logic_res = B;
      OP_BIC:         logic_res = A & ~B;
      OP_MVN:         logic_res = ~B;
      default:        logic_res = A & B;
    endcase
  end
  // Logical ops have no shifter carry, so C and V carry over unchanged
  assign result_d = arith ? sum : logic_res;
  assign flags_d = {result_d[WIDTH-1], result_d == '0,
                    arith ? cout : flags_q[FLAG_C], arith ? ovf : flags_q[FLAG_V]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q <= '0;
    end else if (en) begin
      result_q <= result_d;
      flags_q <= flags_d;
    end
  end
  assign Result = result_q;
  assign ALUFlags = flags_q;
`ifdef ALU_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else if (en) parity_q <= ^result_d;
  end
  assign Parity = parity_q;
`endif
endmodule

// File: tb/tb_alu_32_bits.sv
// tb_alu_32_bits: directed self-checking bench for alu_32_bits
module tb_alu_32_bits;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  ALU_Op = '0;
  logic [31:0] Result;
  logic [3:0]  ALUFlags;
  int checks = 0;
  int errors = 0;
`ifdef ALU_PARITY_EN
  logic Parity;
`endif

  alu_32_bits dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .A(A),
    .B(B),
    .ALU_Op(ALU_Op),
    .Result(Result),
    .ALUFlags(ALUFlags)
`ifdef ALU_PARITY_EN
    ,
    .Parity(Parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input logic e, input logic [31:0] a, input logic [31:0] b,
                    input logic [3:0] o, input logic [31:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    en = e;
    A = a;
    B = b;
    ALU_Op = o;
    @(posedge clk);
    #1;
    check({tag, " result"}, Result, exp_r);
    check({tag, " flags"}, {28'd0, ALUFlags}, {28'd0, exp_f});
  endtask

  initial begin
    #12;
    check("reset result", Result, 32'h0);
    check("reset flags", {28'd0, ALUFlags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    op("AND 0,0", 1, 32'h0, 32'h0, 4'b0000, 32'h0, 4'b0100);
    op("SUB 0,0", 1, 32'h0, 32'h0, 4'b0010, 32'h0, 4'b0110);
    op("MOV 0", 1, 32'h0, 32'h0, 4'b1101, 32'h0, 4'b0110);
    op("SUB 0,1", 1, 32'h0, 32'h1, 4'b0010, 32'hFFFFFFFF, 4'b1000);
    op("RSB 0,1", 1, 32'h0, 32'h1, 4'b0011, 32'h1, 4'b0010);
    op("CMN 0,1", 1, 32'h0, 32'h1, 4'b1011, 32'h1, 4'b0000);
    op("ADD ovf", 1, 32'h7FFFFFFF, 32'h1, 4'b0100, 32'h80000000, 4'b1001);
    op("SUB 7F..,1", 1, 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h7FFFFFFE, 4'b0010);
    op("EOR 7F..,1", 1, 32'h7FFFFFFF, 32'h1, 4'b0001, 32'h7FFFFFFE, 4'b0010);
    op("ADD carry", 1, 32'hFFFFFFFF, 32'h1, 4'b0100, 32'h0, 4'b0110);
    op("ADC cin1", 1, 32'h0, 32'h0, 4'b0101, 32'h1, 4'b0000);
    op("SBC cin0", 1, 32'h5, 32'h3, 4'b0110, 32'h1, 4'b0010);
    op("RSC cin1", 1, 32'h3, 32'h5, 4'b0111, 32'h2, 4'b0010);
    op("ORR", 1, 32'hF0, 32'h0F, 4'b1100, 32'hFF, 4'b0010);
    op("BIC", 1, 32'hFF, 32'h0F, 4'b1110, 32'hF0, 4'b0010);
    op("MVN 0", 1, 32'h1234, 32'h0, 4'b1111, 32'hFFFFFFFF, 4'b1010);
    op("CMP 1,2", 1, 32'h1, 32'h2, 4'b1010, 32'hFFFFFFFF, 4'b1000);
    op("TST", 1, 32'hF0, 32'h0F, 4'b1000, 32'h0, 4'b0100);
    op("TEQ", 1, 32'h5, 32'h5, 4'b1001, 32'h0, 4'b0100);
    op("ADD 3,4", 1, 32'h3, 32'h4, 4'b0100, 32'h7, 4'b0000);
`ifdef ALU_PARITY_EN
    check("parity 7", {31'd0, Parity}, 32'h1);
`endif
    op("hold 1", 0, 32'hFFFFFFFF, 32'h1, 4'b0010, 32'h7, 4'b0000);
    op("hold 2", 0, 32'h80000000, 32'h80000000, 4'b0100, 32'h7, 4'b0000);
    op("hold 3", 0, 32'h0, 32'h0, 4'b1111, 32'h7, 4'b0000);
`ifdef ALU_PARITY_EN
    check("parity hold", {31'd0, Parity}, 32'h1);
`endif
    op("ADD pre-reset", 1, 32'h7FFFFFFF, 32'h1, 4'b0100, 32'h80000000, 4'b1001);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset result", Result, 32'h0);
    check("async reset flags", {28'd0, ALUFlags}, 32'h0);
`ifdef ALU_PARITY_EN
    check("async reset parity", {31'd0, Parity}, 32'h0);
`endif
    @(posedge clk);
    #1;
    check("reset beats en result", Result, 32'h0);
    check("reset beats en flags", {28'd0, ALUFlags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    op("ADD after reset", 1, 32'h1, 32'h1, 4'b0100, 32'h2, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
